mem_access_ctrl: RTL and testbench

Memory-stage controller for the pipelined CPU. It sits between the EX_MEM pipeline register and data memory, and is the producer side of MEM_WB.
- Runs loads and stores over a variable-latency req/ack data-memory handshake.
- Stalls the upstream pipeline while a request is outstanding, and inserts a write-back bubble during the stall.
- Drives the Mem, ALUresult, Rd and WB inputs of MEM_WB.
- Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl_load_extract.sv | 18 +
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] BE_DWORD   = 8'hFF;
  localparam logic       SIZE_DWORD = 1'b0;
  localparam logic       SIZE_BYTE  = 1'b1;

  function automatic logic [7:0] lane_be(input logic [2:0] lane);
    return 8'b1 << lane;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );

endinterface

// File: rtl/mem_access_ctrl_load_extract.sv
// Picks the addressed byte lane for byte loads (zero-extended); doubleword loads pass through.
module load_extract #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        lane,
  input  logic              byte_op,
  output logic [DATA_W-1:0] mem
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    mem     = byte_op ? {{(DATA_W-8){1'b0}}, shifted[7:0]} : rdata;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues loads/stores over a req/ack bus, stalls the pipe while
// a request is outstanding and feeds MEM_WB. Non-memory instructions pass straight through.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        Rd,
  input  logic              WB,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              byte_op,
  output logic [DATA_W-1:0] Mem,
  output logic [ADDR_W-1:0] ALUresult_out,
  output logic [4:0]        Rd_out,
  output logic              WB_out,
  output logic              stall,
  output logic              fault,
  mem_access_ctrl_if.master dm
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          be_q, be_d;
  logic                we_q, we_d;
  logic                size_q, size_d;
  logic [4:0]          rd_q, rd_d;
  logic                wb_q, wb_d;
  logic [DATA_W-1:0]   mem_q, mem_d;
  logic [DATA_W-1:0]   lane_data;
  logic                mem_op;
  logic                illegal;

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .rdata   (dm.rdata),
    .lane    (addr_q[2:0]),
    .byte_op (size_q == SIZE_BYTE),
    .mem     (lane_data)
  );

  always_comb begin
    mem_op  = valid & (MemRead | MemWrite);
    illegal = mem_op & ((MemRead & MemWrite) | (!byte_op && (ALUresult[2:0] != 3'b000)));

    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    size_d        = size_q;
    rd_d          = rd_q;
    wb_d          = wb_q;
    mem_d         = mem_q;
    ALUresult_out = ALUresult;
    Rd_out        = Rd;
    Mem           = '0;
    WB_out        = 1'b0;
    stall         = 1'b0;
    fault         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          WB_out = WB & valid;
        end else if (illegal) begin
          fault = 1'b1;
        end else begin
          addr_d  = ALUresult;
          we_d    = MemWrite;
          size_d  = byte_op ? SIZE_BYTE : SIZE_DWORD;
          rd_d    = Rd;
          wb_d    = WB;
          be_d    = byte_op ? lane_be(ALUresult[2:0]) : BE_DWORD;
          wdata_d = byte_op ? {(DATA_W/8){store_data[7:0]}} : store_data;
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall         = 1'b1;
        ALUresult_out = addr_q;
        Rd_out        = rd_q;
        if (dm.ack) begin
          if (!we_q) begin
            mem_d = lane_data;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        ALUresult_out = addr_q;
        Rd_out        = rd_q;
        if (!we_q) begin
          Mem    = mem_q;
          WB_out = wb_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is asynchronous, so the combinational pipeline controls must also drop while it is held.
    if (!rst) begin
      stall  = 1'b0;
      fault  = 1'b0;
      WB_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_DWORD;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      mem_q   <= mem_d;
    end
  end

  assign dm.req   = (state_q == REQ);
  assign dm.we    = we_q;
  assign dm.addr  = addr_q;
  assign dm.wdata = wdata_q;
  assign dm.be    = be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios followed by random instructions checked
// against a byte-addressed reference memory and simple latency arithmetic.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] ALUresult;
  logic [63:0] store_data;
  logic [4:0]  Rd;
  logic        WB;
  logic        MemRead;
  logic        MemWrite;
  logic        byte_op;
  logic [63:0] Mem;
  logic [63:0] ALUresult_out;
  logic [4:0]  Rd_out;
  logic        WB_out;
  logic        stall;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [63:0] phys_mem [16];
  logic [63:0] ref_mem  [16];

  always #5 clk = ~clk;

  mem_access_ctrl_if dm_bus ();

  mem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .ALUresult     (ALUresult),
    .store_data    (store_data),
    .Rd            (Rd),
    .WB            (WB),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .byte_op       (byte_op),
    .Mem           (Mem),
    .ALUresult_out (ALUresult_out),
    .Rd_out        (Rd_out),
    .WB_out        (WB_out),
    .stall         (stall),
    .fault         (fault),
    .dm            (dm_bus)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input string what,
                             input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, what, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic mr, input logic mw, input logic bop,
                               input logic [63:0] alu, input logic [63:0] sdata,
                               input logic [4:0] rd, input logic wb);
    valid      = v;
    MemRead    = mr;
    MemWrite   = mw;
    byte_op    = bop;
    ALUresult  = alu;
    store_data = sdata;
    Rd         = rd;
    WB         = wb;
  endtask

  task automatic runAlu(input string tag, input logic v, input logic [63:0] alu,
                        input logic [4:0] rd, input logic wb);
    applyStimulus(v, 1'b0, 1'b0, 1'($urandom_range(0, 1)), alu, {$urandom, $urandom}, rd, wb);
    @(negedge clk);
    checkOutput(tag, "alu_out", ALUresult_out, alu);
    checkOutput(tag, "rd_out",  64'(Rd_out),   64'(rd));
    checkOutput(tag, "wb_out",  64'(WB_out),   64'(v & wb));
    checkOutput(tag, "stall",   64'(stall),    64'd0);
    checkOutput(tag, "dm_req",  64'(dm_bus.req), 64'd0);
    checkOutput(tag, "mem",     Mem,           64'd0);
    @(posedge clk); #1;
  endtask

  task automatic runMemOp(input string tag, input logic is_store, input logic bop,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input logic wb, input int waits);
    int          stall_cycles;
    int          idx;
    int          lane;
    int          slave_idx;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_mem;

    idx       = int'(addr % 64'd128) / 8;
    lane      = int'(addr % 64'd8);
    exp_be    = bop ? 8'(1 << lane) : 8'hFF;
    exp_wdata = bop ? 64'(sdata[7:0]) * 64'h0101010101010101 : sdata;

    applyStimulus(1'b1, !is_store, is_store, bop, addr, sdata, rd, wb);
    dm_bus.ack   = 1'b0;
    dm_bus.rdata = {$urandom, $urandom};
    stall_cycles = 0;

    @(negedge clk);
    if (stall) stall_cycles++;
    checkOutput(tag, "launch_req", 64'(dm_bus.req), 64'd0);
    checkOutput(tag, "launch_wb",  64'(WB_out),     64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (stall) stall_cycles++;
      checkOutput(tag, "wait_req",  64'(dm_bus.req), 64'd1);
      checkOutput(tag, "wait_addr", dm_bus.addr,     addr);
      checkOutput(tag, "wait_wb",   64'(WB_out),     64'd0);
      @(posedge clk); #1;
    end

    slave_idx    = int'(dm_bus.addr % 64'd128) / 8;
    dm_bus.ack   = 1'b1;
    dm_bus.rdata = phys_mem[slave_idx];
    @(negedge clk);
    if (stall) stall_cycles++;
    checkOutput(tag, "ack_req",  64'(dm_bus.req), 64'd1);
    checkOutput(tag, "ack_addr", dm_bus.addr,     addr);
    checkOutput(tag, "ack_we",   64'(dm_bus.we),  64'(is_store));
    checkOutput(tag, "ack_be",   64'(dm_bus.be),  64'(exp_be));
    if (is_store) checkOutput(tag, "ack_wdata", dm_bus.wdata, exp_wdata);
    if (dm_bus.req && dm_bus.we) begin
      for (int k = 0; k < 8; k++)
        if (dm_bus.be[k]) phys_mem[slave_idx][8*k +: 8] = dm_bus.wdata[8*k +: 8];
    end
    @(posedge clk); #1;
    dm_bus.ack   = 1'b0;
    dm_bus.rdata = {$urandom, $urandom};

    if (is_store) begin
      if (bop) ref_mem[idx][8*lane +: 8] = sdata[7:0];
      else     ref_mem[idx] = sdata;
      exp_mem = 64'd0;
    end else begin
      exp_mem = bop ? 64'(ref_mem[idx][8*lane +: 8]) : ref_mem[idx];
    end

    @(negedge clk);
    if (stall) stall_cycles++;
    checkOutput(tag, "done_stall",   64'(stall),      64'd0);
    checkOutput(tag, "done_req",     64'(dm_bus.req), 64'd0);
    checkOutput(tag, "done_mem",     Mem,             exp_mem);
    checkOutput(tag, "done_wb",      64'(WB_out),     64'(!is_store & wb));
    checkOutput(tag, "done_rd",      64'(Rd_out),     64'(rd));
    checkOutput(tag, "done_alu",     ALUresult_out,   addr);
    checkOutput(tag, "stall_cycles", 64'(stall_cycles), 64'(waits + 2));
    @(posedge clk); #1;
  endtask

  task automatic runIllegal(input string tag, input logic both, input logic bop,
                            input logic [63:0] addr, input logic [4:0] rd);
    applyStimulus(1'b1, 1'b1, both, bop, addr, {$urandom, $urandom}, rd, 1'b1);
    @(negedge clk);
    checkOutput(tag, "fault",  64'(fault),      64'd1);
    checkOutput(tag, "stall",  64'(stall),      64'd0);
    checkOutput(tag, "dm_req", 64'(dm_bus.req), 64'd0);
    checkOutput(tag, "wb_out", 64'(WB_out),     64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput(tag, "fault_next",  64'(fault),      64'd0);
    checkOutput(tag, "dm_req_next", 64'(dm_bus.req), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] r_addr;
    int          kind;

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
    dm_bus.ack   = 1'b0;
    dm_bus.rdata = 64'd0;
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = {$urandom, $urandom};
      ref_mem[i]  = phys_mem[i];
    end

    @(negedge clk);
    checkOutput("reset", "stall",    64'(stall),         64'd0);
    checkOutput("reset", "fault",    64'(fault),         64'd0);
    checkOutput("reset", "dm_req",   64'(dm_bus.req),    64'd0);
    checkOutput("reset", "dm_we",    64'(dm_bus.we),     64'd0);
    checkOutput("reset", "dm_be",    64'(dm_bus.be),     64'd0);
    checkOutput("reset", "dm_addr",  dm_bus.addr,        64'd0);
    checkOutput("reset", "dm_wdata", dm_bus.wdata,       64'd0);
    checkOutput("reset", "wb_out",   64'(WB_out),        64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed scenarios");
    runAlu("add", 1'b1, 64'h1234, 5'd5, 1'b1);

    phys_mem[8] = 64'hDEADBEEF_00000001;
    ref_mem[8]  = 64'hDEADBEEF_00000001;
    runMemOp("ldur", 1'b0, 1'b0, 64'h40, 64'd0, 5'd7, 1'b1, 2);
    runMemOp("sturb", 1'b1, 1'b1, 64'h43, 64'hAB, 5'd3, 1'b1, 0);

    phys_mem[8] = 64'h0011223344556677;
    ref_mem[8]  = 64'h0011223344556677;
    runMemOp("ldurb", 1'b0, 1'b1, 64'h45, 64'd0, 5'd9, 1'b1, 1);
    runIllegal("misaligned", 1'b0, 1'b0, 64'h44, 5'd2);
    runIllegal("rd_and_wr", 1'b1, 1'b1, 64'h48, 5'd2);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'd0, 5'd4, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_req", "req_before", 64'(dm_bus.req), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_req", "dm_req",  64'(dm_bus.req), 64'd0);
    checkOutput("rst_req", "stall",   64'(stall),      64'd0);
    checkOutput("rst_req", "wb_out",  64'(WB_out),     64'd0);
    checkOutput("rst_req", "dm_be",   64'(dm_bus.be),  64'd0);
    checkOutput("rst_req", "dm_addr", dm_bus.addr,     64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    runAlu("add_after_rst", 1'b1, 64'h5555, 5'd6, 1'b1);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: runAlu("rand_alu", 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        1: begin
          r_addr = 64'($urandom_range(0, 15)) * 64'd8;
          runMemOp("rand_ldur", 1'b0, 1'b0, r_addr, 64'd0, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        2: begin
          r_addr = 64'($urandom_range(0, 127));
          runMemOp("rand_ldurb", 1'b0, 1'b1, r_addr, 64'd0, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        3: begin
          r_addr = 64'($urandom_range(0, 127));
          if ($urandom_range(0, 1) == 1)
            runMemOp("rand_sturb", 1'b1, 1'b1, r_addr, {$urandom, $urandom},
                     5'($urandom_range(0, 31)), 1'b0, $urandom_range(0, 3));
          else
            runMemOp("rand_stur", 1'b1, 1'b0, r_addr & ~64'd7, {$urandom, $urandom},
                     5'($urandom_range(0, 31)), 1'b0, $urandom_range(0, 3));
        end
        default: begin
          r_addr = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(1, 7));
          runIllegal("rand_illegal", 1'($urandom_range(0, 1)), 1'b0, r_addr,
                     5'($urandom_range(0, 31)));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
